gt_miss_controller: RTL and testbench
=====================================

Name: gt_miss_controller

Overview:
- Sequences one access at a time through the direct-mapped L1 line array, the victim cache and main memory.
- On an L1 miss: probes the victim cache; on a victim hit swaps lines, else fetches from memory.
- Evicts the displaced L1 line to the victim cache via fill/evict strobes to the datapath.
- Sits between the core-side requester and the cache datapath.
- Single outstanding request; no reordering.

Parameters:
- ADDR_W, 32, request address width.
- IDX_W, 4, L1 index bits (addr[8:5]).
- MEM_TIMEOUT, 255, max cycles waiting for memory before error response; 8-bit counter.

Ports:
- CLK  in  1  clock, all state on posedge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_addr  in  ADDR_W  byte address.
- req_ready  out  1  high only in IDLE.
- l1_hit  in  1  datapath tag compare for the latched address, valid one cycle after l1_lookup.
- l1_lookup  out  1  one-cycle strobe; datapath indexes with lookup_addr.
- lookup_addr  out  ADDR_W  latched request address, stable from accept to resp_valid.
- vc_probe  out  1  one-cycle victim-cache probe strobe.
- vc_hit  in  1  victim result, valid cycle after vc_probe.
- mem_req_valid  out  1  memory read request, held until mem_req_ready.
- mem_req_ready  in  1  memory accepts.
- mem_resp_valid  in  1  line returned (one-cycle pulse).
- evict_en  out  1  one-cycle: push current L1 line at index into victim cache.
- fill_en  out  1  one-cycle: write L1 line at index.
- fill_src  out  1  0 = memory line, 1 = victim line; meaningful when fill_en=1.
- resp_valid  out  1  one-cycle completion pulse.
- resp_level  out  2  0 = L1 hit, 1 = victim hit, 2 = memory, 3 = timeout error.

Behaviour:
- Reset: state IDLE; req_ready=1; all strobes, mem_req_valid, resp_valid = 0; resp_level=0; lookup_addr=0; timeout counter=0.
- IDLE: req_valid & req_ready -> latch addr, assert l1_lookup next cycle, go LOOKUP.
- LOOKUP (1 cycle, strobe out) -> L1_CHK.
- L1_CHK: l1_hit=1 -> RESP with level 0 (total hit latency 3 cycles accept->resp_valid); else vc_probe, go VC_CHK.
- VC_CHK: vc_hit=1 -> SWAP; else MEM_REQ.
- SWAP: evict_en and fill_en(fill_src=1) in the same cycle; datapath reads old line before write -> RESP level 1.
- MEM_REQ: mem_req_valid=1 until mem_req_ready; the handshake cycle clears it -> MEM_WAIT, counter=0.
- MEM_WAIT: counter increments per cycle.
  - mem_resp_valid -> FILL.
  - counter == MEM_TIMEOUT without response -> RESP level 3, no fill/evict.
- FILL: evict_en and fill_en(fill_src=0) same cycle -> RESP level 2.
- RESP: resp_valid=1 one cycle, resp_level held until next accept -> IDLE.
- Boundaries:
  - mem_resp_valid arriving outside MEM_WAIT is ignored.
  - mem_resp_valid on the same cycle counter hits MEM_TIMEOUT: response wins (FILL).
  - req_valid while busy is not accepted (req_ready=0); requester must hold.
  - Back-to-back: the request may be accepted in the IDLE cycle directly after RESP.
  - RST mid-operation: return to IDLE next edge, drop mem_req_valid immediately, no partial fill/evict strobes.
  - Reset is not a memory abort; a later stray mem_resp_valid is ignored.
- At most one of evict/fill pair per access; never both fill_en and resp_valid in the same cycle.

Optional Feature:
- Macro: GT_MISS_STATS_EN.
- Defined: adds outputs stat_l1_hits, stat_vc_hits, stat_mem_fills, stat_timeouts.
  - Each 32 bits, saturating.
  - Incremented on the RESP cycle per resp_level.
  - Cleared by RST.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then req addr 0x0000_0040 with l1_hit=1 -> resp_valid 3 cycles after accept; resp_level=0; no vc_probe, fill_en or evict_en.
- Miss, vc_hit=1 -> single cycle with evict_en=fill_en=1 and fill_src=1; resp_level=1; mem_req_valid never asserted.
- Miss, vc_hit=0; mem_req_ready delayed 3 cycles; mem_resp_valid 10 cycles later:
  - mem_req_valid held 4 cycles.
  - FILL with fill_src=0, then resp_level=2.
- Miss to memory with no response -> resp_level=3 exactly MEM_TIMEOUT cycles into MEM_WAIT; no fill_en.
- Also: response coincident with timeout -> level 2.
- RST asserted during MEM_WAIT -> next cycle req_ready=1, mem_req_valid=0; stray mem_resp_valid afterwards ignored.
- With GT_MISS_STATS_EN: hit, victim hit, memory fill, timeout in sequence -> each counter = 1; RST clears all to 0.

Source files
------------

// File: rtl/gt_miss_controller.sv
// Miss sequencer: one access at a time through L1, the victim cache and memory.
// Build option GT_MISS_STATS_EN adds saturating per-outcome completion counters.
module gt_miss_controller #(
   parameter int ADDR_W      = 32,
   parameter int IDX_W       = 4,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   input  logic              l1_hit,
   output logic              l1_lookup,
   output logic [ADDR_W-1:0] lookup_addr,
   output logic              vc_probe,
   input  logic              vc_hit,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   output logic              evict_en,
   output logic              fill_en,
   output logic              fill_src,
   output logic              resp_valid,
   output logic [1:0]        resp_level
`ifdef GT_MISS_STATS_EN
   ,
   output logic [31:0]       stat_l1_hits,
   output logic [31:0]       stat_vc_hits,
   output logic [31:0]       stat_mem_fills,
   output logic [31:0]       stat_timeouts
`endif
);

   localparam logic [1:0] LVL_L1  = 2'd0;
   localparam logic [1:0] LVL_VC  = 2'd1;
   localparam logic [1:0] LVL_MEM = 2'd2;
   localparam logic [1:0] LVL_TO  = 2'd3;

   // The line index lives at addr[IDX_W+4:5]; the address must be wide enough to hold it.
   if (ADDR_W < IDX_W + 5) begin : g_bad_cfg
      $error("ADDR_W too narrow for the L1 index field");
   end

   typedef enum logic [3:0] {
      S_IDLE, S_LOOKUP, S_L1_CHK, S_VC_PROBE, S_VC_CHK,
      S_SWAP, S_MEM_REQ, S_MEM_WAIT, S_FILL, S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              l1_lookup_q, l1_lookup_d;
   logic [ADDR_W-1:0] lookup_addr_q, lookup_addr_d;
   logic              vc_probe_q, vc_probe_d;
   logic              mem_req_valid_q, mem_req_valid_d;
   logic              evict_en_q, evict_en_d;
   logic              fill_en_q, fill_en_d;
   logic              fill_src_q, fill_src_d;
   logic              resp_valid_q, resp_valid_d;
   logic [1:0]        resp_level_q, resp_level_d;
   logic [7:0]        cnt_q, cnt_d;

   always_comb begin
      state_d         = state_q;
      req_ready_d     = req_ready_q;
      l1_lookup_d     = 1'b0;
      lookup_addr_d   = lookup_addr_q;
      vc_probe_d      = 1'b0;
      mem_req_valid_d = mem_req_valid_q;
      evict_en_d      = 1'b0;
      fill_en_d       = 1'b0;
      fill_src_d      = fill_src_q;
      resp_valid_d    = 1'b0;
      resp_level_d    = resp_level_q;
      cnt_d           = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               lookup_addr_d = req_addr;
               l1_lookup_d   = 1'b1;
               req_ready_d   = 1'b0;
               state_d       = S_LOOKUP;
            end
         end
         S_LOOKUP: state_d = S_L1_CHK;
         S_L1_CHK: begin
            if (l1_hit) begin
               resp_valid_d = 1'b1;
               resp_level_d = LVL_L1;
               state_d      = S_RESP;
            end else begin
               vc_probe_d = 1'b1;
               state_d    = S_VC_PROBE;
            end
         end
         // vc_hit is only meaningful the cycle after the probe strobe.
         S_VC_PROBE: state_d = S_VC_CHK;
         S_VC_CHK: begin
            if (vc_hit) begin
               evict_en_d = 1'b1;
               fill_en_d  = 1'b1;
               fill_src_d = 1'b1;
               state_d    = S_SWAP;
            end else begin
               mem_req_valid_d = 1'b1;
               state_d         = S_MEM_REQ;
            end
         end
         S_SWAP: begin
            resp_valid_d = 1'b1;
            resp_level_d = LVL_VC;
            state_d      = S_RESP;
         end
         S_MEM_REQ: begin
            if (mem_req_ready) begin
               mem_req_valid_d = 1'b0;
               cnt_d           = 8'd0;
               state_d         = S_MEM_WAIT;
            end
         end
         S_MEM_WAIT: begin
            if (mem_resp_valid) begin
               evict_en_d = 1'b1;
               fill_en_d  = 1'b1;
               fill_src_d = 1'b0;
               state_d    = S_FILL;
            end else if (cnt_q == 8'(MEM_TIMEOUT)) begin
               resp_valid_d = 1'b1;
               resp_level_d = LVL_TO;
               state_d      = S_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_FILL: begin
            resp_valid_d = 1'b1;
            resp_level_d = LVL_MEM;
            state_d      = S_RESP;
         end
         S_RESP: begin
            req_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            req_ready_d     = 1'b1;
            mem_req_valid_d = 1'b0;
            state_d         = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q         <= S_IDLE;
         req_ready_q     <= 1'b1;
         l1_lookup_q     <= 1'b0;
         lookup_addr_q   <= '0;
         vc_probe_q      <= 1'b0;
         mem_req_valid_q <= 1'b0;
         evict_en_q      <= 1'b0;
         fill_en_q       <= 1'b0;
         fill_src_q      <= 1'b0;
         resp_valid_q    <= 1'b0;
         resp_level_q    <= 2'd0;
         cnt_q           <= 8'd0;
      end else begin
         state_q         <= state_d;
         req_ready_q     <= req_ready_d;
         l1_lookup_q     <= l1_lookup_d;
         lookup_addr_q   <= lookup_addr_d;
         vc_probe_q      <= vc_probe_d;
         mem_req_valid_q <= mem_req_valid_d;
         evict_en_q      <= evict_en_d;
         fill_en_q       <= fill_en_d;
         fill_src_q      <= fill_src_d;
         resp_valid_q    <= resp_valid_d;
         resp_level_q    <= resp_level_d;
         cnt_q           <= cnt_d;
      end
   end

   // Reset must kill an in-flight memory request and any datapath write in the same cycle.
   assign mem_req_valid = mem_req_valid_q & ~RST;
   assign evict_en      = evict_en_q & ~RST;
   assign fill_en       = fill_en_q & ~RST;
   assign req_ready     = req_ready_q;
   assign l1_lookup     = l1_lookup_q;
   assign lookup_addr   = lookup_addr_q;
   assign vc_probe      = vc_probe_q;
   assign fill_src      = fill_src_q;
   assign resp_valid    = resp_valid_q;
   assign resp_level    = resp_level_q;

`ifdef GT_MISS_STATS_EN
   // Counter slot indexed directly by resp_level.
   logic [3:0][31:0] stat_q, stat_d;

   always_comb begin
      stat_d = stat_q;
      if (resp_valid_q && (stat_q[resp_level_q] != 32'hFFFF_FFFF)) begin
         stat_d[resp_level_q] = stat_q[resp_level_q] + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stat_l1_hits   = stat_q[0];
   assign stat_vc_hits   = stat_q[1];
   assign stat_mem_fills = stat_q[2];
   assign stat_timeouts  = stat_q[3];
`endif

endmodule

// File: tb/tb_gt_miss_controller.sv
// Randomized bench for gt_miss_controller; build with GT_MISS_STATS_EN to cover the counters.
module tb_gt_miss_controller;
   localparam int ADDR_W = 32;
   localparam int TO     = 255;
   localparam int BUDGET = 700;

   logic              CLK = 1'b0;
   logic              RST;
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              l1_hit;
   logic              l1_lookup;
   logic [ADDR_W-1:0] lookup_addr;
   logic              vc_probe;
   logic              vc_hit;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_resp_valid;
   logic              evict_en;
   logic              fill_en;
   logic              fill_src;
   logic              resp_valid;
   logic [1:0]        resp_level;
`ifdef GT_MISS_STATS_EN
   logic [31:0] stat_l1_hits, stat_vc_hits, stat_mem_fills, stat_timeouts;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   gt_miss_controller #(.ADDR_W(ADDR_W), .IDX_W(4), .MEM_TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .l1_hit(l1_hit), .l1_lookup(l1_lookup), .lookup_addr(lookup_addr),
      .vc_probe(vc_probe), .vc_hit(vc_hit),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid),
      .evict_en(evict_en), .fill_en(fill_en), .fill_src(fill_src),
      .resp_valid(resp_valid), .resp_level(resp_level)
`ifdef GT_MISS_STATS_EN
      , .stat_l1_hits(stat_l1_hits), .stat_vc_hits(stat_vc_hits),
      .stat_mem_fills(stat_mem_fills), .stat_timeouts(stat_timeouts)
`endif
   );

   // Outcome of an access from the rules: L1 first, then victim, then memory unless it times out.
   function automatic logic [1:0] exp_level(input bit l1h, input bit vch, input int rsp_dly);
      if (l1h) return 2'd0;
      if (vch) return 2'd1;
      if (rsp_dly <= TO) return 2'd2;
      return 2'd3;
   endfunction

   // Runs one access from an IDLE negedge. rsp_dly is the MEM_WAIT cycle index of the response.
   // abort_mode: 0 none, 1 reset during the memory request, 2 reset during the memory wait.
   task automatic do_access(input logic [31:0] addr, input bit l1h, input bit vch,
                            input int rdy_dly, input int rsp_dly, input int abort_mode);
      logic [1:0] lvl_exp;
      logic [1:0] lvl = 2'd0;
      int n_lookup = 0, lookup_cyc = -1, n_probe = 0, probe_cyc = -1;
      int n_evict = 0, evict_cyc = -1, n_fill = 0, fill_cyc = -1;
      int mv_cnt = 0, hs_cyc = -1, resp_cyc = -1, k;
      bit prev_lookup = 0, prev_probe = 0, src = 0, overlap = 0, done = 0;
      lvl_exp = exp_level(l1h, vch, rsp_dly);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL accept_ready: req_ready=%b expected 1", req_ready);
      end
      req_valid = 1'b1;
      req_addr  = addr;
      for (int cyc = 1; cyc < BUDGET && !done; cyc++) begin
         @(negedge CLK);
         req_valid = 1'($urandom);
         req_addr  = $urandom;
         checks++;
         if (req_ready !== 1'b0 || lookup_addr !== addr) begin
            errors++;
            $display("FAIL busy_hold cyc=%0d: req_ready=%b lookup_addr=%h expected 0/%h",
                     cyc, req_ready, lookup_addr, addr);
         end
         if (l1_lookup === 1'b1) begin n_lookup++; lookup_cyc = cyc; end
         if (vc_probe === 1'b1) begin n_probe++; probe_cyc = cyc; end
         if (mem_req_valid === 1'b1) mv_cnt++;
         if (evict_en === 1'b1) begin n_evict++; evict_cyc = cyc; end
         if (fill_en === 1'b1) begin n_fill++; fill_cyc = cyc; src = fill_src; end
         if (resp_valid === 1'b1) begin
            done = 1; resp_cyc = cyc; lvl = resp_level; overlap = (fill_en === 1'b1);
         end
         if ((abort_mode == 1 && mv_cnt == 2) ||
             (abort_mode == 2 && hs_cyc >= 0 && cyc == hs_cyc + 6)) begin
            RST = 1'b1;
            #1;
            checks++;
            if (mem_req_valid !== 1'b0 || fill_en !== 1'b0 || evict_en !== 1'b0) begin
               errors++;
               $display("FAIL rst_drop: mem_req_valid=%b fill_en=%b evict_en=%b expected 0/0/0",
                        mem_req_valid, fill_en, evict_en);
            end
            @(negedge CLK);
            RST = 1'b0;
            req_valid = 1'b0;
            checks++;
            if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || resp_valid !== 1'b0 ||
                l1_lookup !== 1'b0 || vc_probe !== 1'b0) begin
               errors++;
               $display("FAIL rst_idle: req_ready=%b mem_req_valid=%b resp_valid=%b expected 1/0/0",
                        req_ready, mem_req_valid, resp_valid);
            end
            return;
         end
         l1_hit = prev_lookup ? l1h : 1'($urandom);
         vc_hit = prev_probe ? vch : 1'($urandom);
         prev_lookup = (l1_lookup === 1'b1);
         prev_probe  = (vc_probe === 1'b1);
         if (mem_req_valid === 1'b1 && hs_cyc < 0) begin
            mem_req_ready = (mv_cnt == rdy_dly + 1);
            if (mem_req_ready) hs_cyc = cyc;
         end else begin
            mem_req_ready = 1'($urandom);
         end
         k = cyc - hs_cyc - 1;
         if (hs_cyc >= 0 && k >= 0 && k <= rsp_dly && k <= TO) mem_resp_valid = (k == rsp_dly);
         else mem_resp_valid = 1'($urandom);
      end
      checks++;
      if (!done) begin
         errors++; $display("FAIL no_resp: resp_valid never seen within %0d cycles", BUDGET);
      end
      checks++;
      if (lvl !== lvl_exp) begin
         errors++; $display("FAIL level: resp_level=%0d expected %0d", lvl, lvl_exp);
      end
      checks++;
      if (n_lookup != 1 || lookup_cyc != 1) begin
         errors++; $display("FAIL lookup: strobes=%0d at cyc %0d expected 1 at cyc 1", n_lookup, lookup_cyc);
      end
      checks++;
      if (overlap) begin
         errors++; $display("FAIL fill_resp_overlap: fill_en=1 with resp_valid=1 expected fill_en=0");
      end
      if (l1h) begin
         checks++;
         if (resp_cyc != 3) begin
            errors++; $display("FAIL hit_latency: resp at cyc %0d expected 3", resp_cyc);
         end
         checks++;
         if (n_probe != 0 || n_fill != 0 || n_evict != 0 || mv_cnt != 0) begin
            errors++;
            $display("FAIL hit_side: probe=%0d fill=%0d evict=%0d memreq=%0d expected all 0",
                     n_probe, n_fill, n_evict, mv_cnt);
         end
      end else if (vch) begin
         checks++;
         if (n_probe != 1 || mv_cnt != 0) begin
            errors++; $display("FAIL vc_probe: probe=%0d memreq=%0d expected 1/0", n_probe, mv_cnt);
         end
         checks++;
         if (n_fill != 1 || n_evict != 1 || fill_cyc != evict_cyc || src !== 1'b1 ||
             resp_cyc != fill_cyc + 1 || fill_cyc <= probe_cyc) begin
            errors++;
            $display("FAIL swap: fill=%0d@%0d evict=%0d@%0d src=%b resp@%0d expected 1/1 same cyc src 1 resp next",
                     n_fill, fill_cyc, n_evict, evict_cyc, src, resp_cyc);
         end
      end else begin
         checks++;
         if (n_probe != 1 || mv_cnt != rdy_dly + 1 || hs_cyc < 0) begin
            errors++;
            $display("FAIL mem_req: probe=%0d mem_req_valid cycles=%0d expected 1/%0d",
                     n_probe, mv_cnt, rdy_dly + 1);
         end
         if (lvl_exp == 2'd2) begin
            checks++;
            if (n_fill != 1 || n_evict != 1 || fill_cyc != evict_cyc || src !== 1'b0 ||
                fill_cyc != hs_cyc + rsp_dly + 2 || resp_cyc != fill_cyc + 1) begin
               errors++;
               $display("FAIL mem_fill: fill=%0d@%0d evict=%0d@%0d src=%b resp@%0d expected fill@%0d src 0",
                        n_fill, fill_cyc, n_evict, evict_cyc, src, resp_cyc, hs_cyc + rsp_dly + 2);
            end
         end else begin
            checks++;
            if (n_fill != 0 || n_evict != 0 || resp_cyc != hs_cyc + TO + 2) begin
               errors++;
               $display("FAIL timeout: fill=%0d evict=%0d resp@%0d expected 0/0 resp@%0d",
                        n_fill, n_evict, resp_cyc, hs_cyc + TO + 2);
            end
         end
      end
      req_valid = 1'b0;
      @(negedge CLK);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_level !== lvl_exp || fill_en !== 1'b0) begin
         errors++;
         $display("FAIL after_resp: req_ready=%b resp_valid=%b resp_level=%0d expected 1/0/%0d",
                  req_ready, resp_valid, resp_level, lvl_exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid      = 1'b0;
         l1_hit         = 1'($urandom);
         vc_hit         = 1'($urandom);
         mem_req_ready  = 1'($urandom);
         mem_resp_valid = 1'($urandom);
         @(negedge CLK);
         checks++;
         if (req_ready !== 1'b1 || l1_lookup !== 1'b0 || vc_probe !== 1'b0 || mem_req_valid !== 1'b0 ||
             fill_en !== 1'b0 || evict_en !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: ready=%b lookup=%b probe=%b memreq=%b fill=%b evict=%b resp=%b expected 1/0/0/0/0/0/0",
                     req_ready, l1_lookup, vc_probe, mem_req_valid, fill_en, evict_en, resp_valid);
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; req_valid = 1'b0; req_addr = '0; l1_hit = 1'b0; vc_hit = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      repeat (2) @(negedge CLK);
      checks++;
      if (req_ready !== 1'b1 || l1_lookup !== 1'b0 || vc_probe !== 1'b0 || mem_req_valid !== 1'b0 ||
          evict_en !== 1'b0 || fill_en !== 1'b0 || resp_valid !== 1'b0 || resp_level !== 2'd0 ||
          lookup_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: ready=%b lookup=%b probe=%b memreq=%b evict=%b fill=%b resp=%b level=%0d addr=%h expected 1/0/0/0/0/0/0/0/0",
                  req_ready, l1_lookup, vc_probe, mem_req_valid, evict_en, fill_en, resp_valid,
                  resp_level, lookup_addr);
      end
      RST = 1'b0;
      idle(2);
   endtask

   task automatic test_l1_hit();
      do_access(32'h0000_0040, 1'b1, 1'b0, 0, 0, 0);
      idle(1);
   endtask

   task automatic test_victim_hit();
      do_access($urandom, 1'b0, 1'b1, 0, 0, 0);
      idle(1);
   endtask

   task automatic test_mem_fill();
      do_access($urandom, 1'b0, 1'b0, 3, 10, 0);
      idle(1);
   endtask

   task automatic test_timeout();
      do_access($urandom, 1'b0, 1'b0, 0, 1000, 0);
      idle(1);
      do_access($urandom, 1'b0, 1'b0, 1, TO, 0);
      idle(1);
   endtask

   task automatic test_reset_mid_op();
      do_access($urandom, 1'b0, 1'b0, 3, 1000, 1);
      mem_resp_valid = 1'b1;
      req_valid = 1'b0;
      @(negedge CLK);
      idle(3);
      do_access($urandom, 1'b0, 1'b0, 0, 1000, 2);
      mem_resp_valid = 1'b1;
      req_valid = 1'b0;
      @(negedge CLK);
      idle(4);
      do_access($urandom, 1'b1, 1'b0, 0, 0, 0);
      idle(1);
   endtask

   task automatic test_back_to_back();
      do_access($urandom, 1'b1, 1'b0, 0, 0, 0);
      do_access($urandom, 1'b0, 1'b1, 0, 0, 0);
      do_access($urandom, 1'b0, 1'b0, 0, 0, 0);
      do_access($urandom, 1'b1, 1'b1, 2, 0, 0);
      idle(1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         bit l1h, vch;
         int rdy, rsp, gap;
         l1h = ($urandom_range(0, 2) == 0);
         vch = ($urandom_range(0, 1) == 0);
         rdy = $urandom_range(0, 4);
         if ($urandom_range(0, 9) == 0) rsp = $urandom_range(TO - 2, TO + 1);
         else rsp = $urandom_range(0, 20);
         do_access($urandom, l1h, vch, rdy, rsp, 0);
         gap = $urandom_range(0, 2);
         if (gap > 0) idle(gap);
      end
   endtask

`ifdef GT_MISS_STATS_EN
   task automatic test_stats();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      checks++;
      if (stat_l1_hits !== 0 || stat_vc_hits !== 0 || stat_mem_fills !== 0 || stat_timeouts !== 0) begin
         errors++;
         $display("FAIL stats_reset: %0d %0d %0d %0d expected 0 0 0 0",
                  stat_l1_hits, stat_vc_hits, stat_mem_fills, stat_timeouts);
      end
      do_access($urandom, 1'b1, 1'b0, 0, 0, 0);
      do_access($urandom, 1'b0, 1'b1, 0, 0, 0);
      do_access($urandom, 1'b0, 1'b0, 1, 5, 0);
      do_access($urandom, 1'b0, 1'b0, 0, 1000, 0);
      checks++;
      if (stat_l1_hits !== 1 || stat_vc_hits !== 1 || stat_mem_fills !== 1 || stat_timeouts !== 1) begin
         errors++;
         $display("FAIL stats_count: %0d %0d %0d %0d expected 1 1 1 1",
                  stat_l1_hits, stat_vc_hits, stat_mem_fills, stat_timeouts);
      end
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      checks++;
      if (stat_l1_hits !== 0 || stat_vc_hits !== 0 || stat_mem_fills !== 0 || stat_timeouts !== 0) begin
         errors++;
         $display("FAIL stats_clear: %0d %0d %0d %0d expected 0 0 0 0",
                  stat_l1_hits, stat_vc_hits, stat_mem_fills, stat_timeouts);
      end
      idle(1);
   endtask
`endif

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_l1_hit();
      test_victim_hit();
      test_mem_fill();
      test_timeout();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
`ifdef GT_MISS_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
